// File: rtl/serial_cla_adder_pkg.sv
// ============================================================================
// Module  : serial_cla_adder_pkg
// Brief   : Shared slice width and FSM state encoding for serial_cla_adder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package serial_cla_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_cla_adder_cla4_slice.sv
// ============================================================================
// Module  : cla4_slice
// Brief   : Combinational 4-bit carry-lookahead slice with group P/G outputs.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       gp,
  output logic       gg
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:1] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Every carry is a flat sum of products of p/g and cin: no ripple chain.
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign gp = &w_p;
  assign gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

  assign cout = gg | (gp & cin);
  assign s    = w_p ^ {w_c[3:1], cin};

endmodule

`default_nettype wire

// File: rtl/serial_cla_adder.sv
// ============================================================================
// Module  : serial_cla_adder
// Brief   : WIDTH-bit adder evaluated one 4-bit lookahead slice per clock.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module serial_cla_adder
  import serial_cla_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] c_last = IDX_W'(NSLICE - 1);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("serial_cla_adder: WIDTH must be a positive multiple of 4");
  end

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic [SLICE_W-1:0] w_s;
  logic               w_cout;

  cla4_slice u_slice (
    .a    (r_a[SLICE_W*r_idx +: SLICE_W]),
    .b    (r_b[SLICE_W*r_idx +: SLICE_W]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout),
    .gp   (),
    .gg   ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)        w_next = RUN;
      RUN:     if (r_idx == c_last) w_next = DONE;
      DONE:    if (out_ready)       w_next = IDLE;
      default:                      w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        RUN: begin
          r_sum[SLICE_W*r_idx +: SLICE_W] <= w_s;
          r_carry <= w_cout;
          if (r_idx == c_last) begin
            r_cout <= w_cout;
            // Operand MSBs xor sum MSB recovers the carry into the top bit.
            r_ovf  <= w_cout ^ (r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s[SLICE_W-1]);
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_cla_adder.sv
// ============================================================================
// Module  : tb_serial_cla_adder
// Brief   : Directed self-checking bench for serial_cla_adder at WIDTH=16.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_cla_adder;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks   = 0;
  int failures = 0;

  serial_cla_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operand set and wait (bounded) for out_valid; result is left pending.
  task automatic issue_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic icin, output logic rdy, output int lat,
                          output logic timeout);
    @(negedge clk);
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    cin      = icin;
    rdy      = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    lat      = 0;
    timeout  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat     = i;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if ({out_valid, sum, cout, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got out_valid=%b sum=%h cout=%b ovf=%b exp all 0",
               out_valid, sum, cout, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full transaction with inline checks on acceptance, latency and result.
  task automatic test_add(input string name, input logic [WIDTH-1:0] ia,
                          input logic [WIDTH-1:0] ib, input logic icin,
                          input logic [WIDTH-1:0] esum, input logic ecout,
                          input logic eovf);
    logic rdy;
    int   lat;
    logic to;
    issue_op(ia, ib, icin, rdy, lat, to);
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready got=%b exp=1", name, rdy);
    end
    checks++;
    if (to || lat != 4) begin
      failures++;
      $display("FAIL %s_latency got=%0d timeout=%b exp=4", name, lat, to);
    end
    checks++;
    if (sum !== esum) begin
      failures++;
      $display("FAIL %s_sum got=%h exp=%h", name, sum, esum);
    end
    checks++;
    if (cout !== ecout || ovf !== eovf) begin
      failures++;
      $display("FAIL %s_flags got cout=%b ovf=%b exp cout=%b ovf=%b",
               name, cout, ovf, ecout, eovf);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_after_consume got out_valid=%b in_ready=%b exp 0/1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic rdy;
    int   lat;
    logic to;
    issue_op(16'h1234, 16'h4321, 1'b0, rdy, lat, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL bp_first_result got=timeout exp=out_valid");
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = 16'hA5A5 + 16'(i * 16'h1111);
      b        = 16'h0F0F ^ 16'(i);
      cin      = i[0];
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h5555 ||
          cout !== 1'b0 || ovf !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d got out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b exp 1/0/5555/0/0",
                 i, out_valid, in_ready, sum, cout, ovf);
      end
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    test_add("bp_next", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    logic saw_valid;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'h0001;
    cin      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_running got in_ready=%b exp=0", in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_immediate got out_valid=%b sum=%h cout=%b in_ready=%b exp 0/0000/0/1",
               out_valid, sum, cout, in_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      failures++;
      $display("FAIL abort_no_stale got=out_valid_or_busy exp=idle");
    end
    test_add("abort_next", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add("basic",     16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    test_add("ripple",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_add("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_add("neg_ovf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    test_add("all_ones",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    test_add("cin_only",  16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    test_backpressure();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
